// File: rtl/wb_btn_pkg.sv
// Shared definitions for the push-button Wishbone slave: register offsets,
// Wishbone cycle/burst type codes, bus FSM states and a byte-select helper.
package wb_btn_pkg;

  localparam logic [3:0] OFS_DATA = 4'd0;
  localparam logic [3:0] OFS_RAW  = 4'd1;
  localparam logic [3:0] OFS_EDGE = 4'd2;
  localparam logic [3:0] OFS_IEN  = 4'd3;
  localparam logic [3:0] OFS_DEB  = 4'd4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP,
    ST_BURST
  } wb_state_e;

  // Expand the four byte selects into a 32-bit write mask.
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, programmable tick prescaler and two-sample debouncer
// for NB button lines.
module btn_debounce
  import wb_btn_pkg::*;
#(
  parameter int NB = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   deb_cnt,
  input  logic          restart,
  input  logic [NB-1:0] btn,
  output logic [NB-1:0] raw,
  output logic [NB-1:0] data
);

  logic [NB-1:0] meta_reg;
  logic [NB-1:0] raw_reg;
  logic [NB-1:0] smp_reg;
  logic [NB-1:0] data_reg;
  logic [NB-1:0] data_next;
  logic [15:0]   presc_reg;
  logic          tick;

  // A reload write takes priority over the wrap so the new period starts cleanly.
  assign tick = !restart && (presc_reg >= deb_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg  <= '0;
      raw_reg   <= '0;
      smp_reg   <= '0;
      presc_reg <= '0;
      data_reg  <= '0;
    end else begin
      meta_reg  <= btn;
      raw_reg   <= meta_reg;
      presc_reg <= (restart || tick) ? 16'd0 : presc_reg + 16'd1;
      if (tick) begin
        smp_reg <= raw_reg;
      end
      data_reg  <= data_next;
    end
  end

  // A bit is accepted only when two consecutive tick samples agree.
  for (genvar gi = 0; gi < NB; gi++) begin : g_bit
    assign data_next[gi] = (tick && (raw_reg[gi] == smp_reg[gi])) ? smp_reg[gi] : data_reg[gi];
  end

  assign raw  = raw_reg;
  assign data = data_reg;

endmodule

// File: rtl/wb_btn_slave.sv
// Wishbone B4 slave for the push-button window: bus FSM with classic and
// linear incrementing bursts, edge capture, interrupt enable and debounce reload.
module wb_btn_slave
  import wb_btn_pkg::*;
#(
  parameter int          NB      = 8,
  parameter logic [15:0] DEB_RST = 16'd50000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  input  logic [NB-1:0] btn_i,
  output logic          irq_o
);

  wb_state_e     state_reg;
  logic          ack_reg;
  logic          err_reg;
  logic [31:0]   dat_reg;
  logic          irq_reg;
  logic [NB-1:0] edge_reg;
  logic [NB-1:0] edge_next;
  logic [NB-1:0] ien_reg;
  logic [NB-1:0] data_prev_reg;
  logic [15:0]   deb_reg;

  logic [NB-1:0] raw;
  logic [NB-1:0] data;
  logic [NB-1:0] rise;
  logic [NB-1:0] clr;
  logic [3:0]    ofs;
  logic          req;
  logic          bad;
  logic          wr_ok;
  logic          burst_go;
  logic          deb_restart;
  logic [31:0]   wmask;
  logic [31:0]   rd_data;
  logic          unused_ok;

  assign ofs      = wb_adr_i[5:2];
  assign wmask    = sel_mask(wb_sel_i);
  // In a burst the slave keeps accepting while ack is high; only the
  // terminating response cycle blocks a new request.
  assign req      = wb_cyc_i && wb_stb_i && (state_reg != ST_RESP);
  assign bad      = (ofs > OFS_DEB) || (wb_we_i && ((ofs == OFS_DATA) || (ofs == OFS_RAW)));
  assign wr_ok    = req && wb_we_i && !bad;
  assign burst_go = (wb_cti_i == CTI_INCR) && (wb_bte_i == BTE_LINEAR);
  assign deb_restart = wr_ok && (ofs == OFS_DEB);

  assign unused_ok = &{1'b0, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:16], wmask[31:16]};

  btn_debounce #(.NB(NB)) u_deb (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .deb_cnt (deb_reg),
    .restart (deb_restart),
    .btn     (btn_i),
    .raw     (raw),
    .data    (data)
  );

  always_comb begin
    rd_data = '0;
    case (ofs)
      OFS_DATA: rd_data = 32'(data);
      OFS_RAW:  rd_data = 32'(raw);
      OFS_EDGE: rd_data = 32'(edge_reg);
      OFS_IEN:  rd_data = 32'(ien_reg);
      OFS_DEB:  rd_data = {16'd0, deb_reg};
      default:  rd_data = '0;
    endcase
  end

  // New rising edges override a simultaneous write-1-to-clear.
  assign rise      = data & ~data_prev_reg;
  assign clr       = (wr_ok && (ofs == OFS_EDGE)) ? (wb_dat_i[NB-1:0] & wmask[NB-1:0]) : '0;
  assign edge_next = (edge_reg & ~clr) | rise;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg <= ST_IDLE;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_reg   <= '0;
    end else if (req) begin
      ack_reg   <= !bad;
      err_reg   <= bad;
      dat_reg   <= (bad || wb_we_i) ? 32'd0 : rd_data;
      state_reg <= (!bad && burst_go) ? ST_BURST : ST_RESP;
    end else begin
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_reg   <= '0;
      state_reg <= ST_IDLE;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      edge_reg      <= '0;
      ien_reg       <= '0;
      data_prev_reg <= '0;
      deb_reg       <= DEB_RST;
      irq_reg       <= 1'b0;
    end else begin
      data_prev_reg <= data;
      edge_reg      <= edge_next;
      irq_reg       <= |(edge_reg & ien_reg);
      if (wr_ok && (ofs == OFS_IEN)) begin
        ien_reg <= (ien_reg & ~wmask[NB-1:0]) | (wb_dat_i[NB-1:0] & wmask[NB-1:0]);
      end
      if (deb_restart) begin
        deb_reg <= (deb_reg & ~wmask[15:0]) | (wb_dat_i[15:0] & wmask[15:0]);
      end
    end
  end

  assign wb_ack_o = ack_reg;
  assign wb_err_o = err_reg;
  assign wb_dat_o = dat_reg;
  assign wb_rty_o = 1'b0;
  assign irq_o    = irq_reg;

endmodule

// File: tb/tb_wb_btn_slave.sv
// Self-checking bench for wb_btn_slave: register table, debounce/edge/irq
// sequences, bursts, randomized accesses against a register-level model.
module tb_wb_btn_slave;
  localparam int NB = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   adr   = '0;
  logic [31:0]   dat_i = '0;
  logic [3:0]    sel   = '0;
  logic          we    = 1'b0;
  logic          cyc   = 1'b0;
  logic          stb   = 1'b0;
  logic [2:0]    cti   = '0;
  logic [1:0]    bte   = '0;
  logic [NB-1:0] btn   = '0;
  logic [31:0]   dat_o;
  logic          ack, err, rty, irq;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_cnt  = 0;
  logic mon_on   = 1'b0;
  logic irq_seen = 1'b0;

  // Register-level model of the visible state
  logic [7:0]  btn_m, edge_m, ien_m;
  logic [15:0] deb_m;

  logic        r_ack, r_err, r_rty, r_ack2, r_irq0, r_irq1;
  logic [31:0] r_dat;

  typedef struct packed {
    logic        we;
    logic [3:0]  ofs;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vt [22];

  wb_btn_slave #(.NB(NB), .DEB_RST(16'd50000)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_cti_i  (cti),
    .wb_bte_i  (bte),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .wb_rty_o  (rty),
    .btn_i     (btn),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (mon_on && irq) irq_seen = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] model_rd(input logic [3:0] o);
    case (o)
      4'd0, 4'd1: return {24'd0, btn_m};
      4'd2:       return {24'd0, edge_m};
      4'd3:       return {24'd0, ien_m};
      4'd4:       return {16'd0, deb_m};
      default:    return 32'd0;
    endcase
  endfunction

  task automatic model_wr(input logic [3:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = bmask(s);
    case (o)
      4'd2: edge_m = edge_m & ~(d[7:0] & m[7:0]);
      4'd3: ien_m  = (ien_m & ~m[7:0]) | (d[7:0] & m[7:0]);
      4'd4: deb_m  = (deb_m & ~m[15:0]) | (d[15:0] & m[15:0]);
      default: ;
    endcase
  endtask

  // Classic single transfer; called and returns at posedge+1.
  task automatic xfer(input logic w, input logic [3:0] o, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {26'd0, o, 2'b00}; dat_i = d; sel = s;
    cti = 3'b000; bte = 2'b00;
    step();
    r_ack = ack; r_err = err; r_dat = dat_o; r_rty = rty; r_irq0 = irq;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
    r_ack2 = ack | err; r_irq1 = irq;
    $display("xfer %s ofs=%0d wdat=0x%08h sel=%b -> ack=%0b err=%0b dat=0x%08h",
             w ? "WR" : "RD", o, d, s, r_ack, r_err, r_dat);
  endtask

  initial begin
    logic [31:0] bexp [4];
    logic [31:0] d, wd;
    logic [3:0]  o, s;
    logic        w, bad, found;
    int          t0, lat, n_one, n_zero;
    logic [7:0]  newp;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rty", rty, 0);
    rst_n = 1'b1;
    step();

    // Register table
    vt[0]  = '{1'b0, 4'd0,  32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 4'd1,  32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 4'd2,  32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 4'd3,  32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 4'd4,  32'h0,        4'hF, 1'b1, 1'b0, 32'h0000C350};
    vt[5]  = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'h1, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 4'd3,  32'h0,        4'hF, 1'b1, 1'b0, 32'h000000FF};
    vt[7]  = '{1'b1, 4'd3,  32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 4'd3,  32'h0,        4'hF, 1'b1, 1'b0, 32'h000000FF};
    vt[9]  = '{1'b1, 4'd3,  32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    vt[10] = '{1'b0, 4'd3,  32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    vt[11] = '{1'b1, 4'd4,  32'h12345678, 4'h3, 1'b1, 1'b0, 32'h0};
    vt[12] = '{1'b0, 4'd4,  32'h0,        4'hF, 1'b1, 1'b0, 32'h00005678};
    vt[13] = '{1'b1, 4'd4,  32'h0000AB00, 4'h2, 1'b1, 1'b0, 32'h0};
    vt[14] = '{1'b0, 4'd4,  32'h0,        4'hF, 1'b1, 1'b0, 32'h0000AB78};
    vt[15] = '{1'b0, 4'd5,  32'h0,        4'hF, 1'b0, 1'b1, 32'h0};
    vt[16] = '{1'b0, 4'd15, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0};
    vt[17] = '{1'b1, 4'd0,  32'hFF,       4'hF, 1'b0, 1'b1, 32'h0};
    vt[18] = '{1'b1, 4'd1,  32'hFF,       4'hF, 1'b0, 1'b1, 32'h0};
    vt[19] = '{1'b1, 4'd4,  32'h00000003, 4'h3, 1'b1, 1'b0, 32'h0};
    vt[20] = '{1'b0, 4'd4,  32'h0,        4'hF, 1'b1, 1'b0, 32'h00000003};
    vt[21] = '{1'b0, 4'd0,  32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 22; i++) begin
      xfer(vt[i].we, vt[i].ofs, vt[i].wd, vt[i].sel);
      chk($sformatf("tbl%0d_ack", i), r_ack, vt[i].exp_ack);
      chk($sformatf("tbl%0d_err", i), r_err, vt[i].exp_err);
      chk($sformatf("tbl%0d_rty", i), r_rty, 0);
      chk($sformatf("tbl%0d_low_after", i), r_ack2, 0);
      if (!vt[i].we) chk($sformatf("tbl%0d_dat", i), r_dat, vt[i].exp_dat);
    end
    btn_m = '0; edge_m = '0; ien_m = '0; deb_m = 16'd3;

    // Debounce latency, edge latch and irq timing
    btn[2] = 1'b1; t0 = cyc_cnt; found = 1'b0; lat = 999;
    for (int i = 0; i < 12 && !found; i++) begin
      xfer(1'b0, 4'd0, 32'h0, 4'hF);
      if (r_dat[2]) begin found = 1'b1; lat = cyc_cnt - t0; end
    end
    chk("deb_found", found, 1);
    chk("deb_latency_le12", lat <= 12, 1);
    btn_m = 8'h04; edge_m = 8'h04;
    xfer(1'b0, 4'd2, 32'h0, 4'hF);
    chk("edge_after_rise", r_dat, 32'h04);
    xfer(1'b1, 4'd3, 32'h04, 4'hF);
    ien_m = 8'h04;
    chk("irq_before_ien", r_irq0, 0);
    chk("irq_one_cycle_later", r_irq1, 1);

    // Short glitch must be rejected
    btn[0] = 1'b1; step(); step(); btn[0] = 1'b0;
    repeat (24) step();
    xfer(1'b0, 4'd0, 32'h0, 4'hF);
    chk("glitch_data", r_dat, 32'h04);
    xfer(1'b0, 4'd2, 32'h0, 4'hF);
    chk("glitch_edge", r_dat, 32'h04);

    // Write-1-to-clear with a single byte lane
    xfer(1'b1, 4'd2, 32'h04, 4'h1);
    edge_m = 8'h00;
    chk("w1c_irq_at_resp", r_irq0, 1);
    chk("w1c_irq_cleared", r_irq1, 0);
    xfer(1'b0, 4'd2, 32'h0, 4'hF);
    chk("w1c_edge", r_dat, 32'h0);

    // Clear sweep across the rising edge: an edge may never vanish unseen
    n_one = 0; n_zero = 0;
    for (int k = 0; k < 16; k++) begin
      btn[2] = 1'b0;
      repeat (30) step();
      xfer(1'b1, 4'd2, 32'hFF, 4'h1);
      repeat (2) step();
      xfer(1'b1, 4'd4, 32'h3, 4'hF);
      btn[2] = 1'b1; irq_seen = 1'b0; mon_on = 1'b1;
      repeat (k) step();
      xfer(1'b1, 4'd2, 32'h04, 4'h1);
      repeat (20) step();
      mon_on = 1'b0;
      xfer(1'b0, 4'd2, 32'h0, 4'hF);
      chk($sformatf("set_wins_k%0d", k), r_dat[2] | irq_seen, 1);
      if (r_dat[2]) n_one++; else n_zero++;
    end
    chk("sweep_some_kept", n_one > 0, 1);
    chk("sweep_some_cleared", n_zero > 0, 1);
    xfer(1'b1, 4'd2, 32'hFF, 4'h1);
    edge_m = 8'h00;
    repeat (2) step();

    // Linear burst read of offsets 0..3
    for (int b = 0; b < 4; b++) bexp[b] = model_rd(4'(b));
    cyc = 1'b1; stb = 1'b1; we = 1'b0; bte = 2'b00; sel = 4'hF;
    for (int b = 0; b < 4; b++) begin
      adr = 32'(b * 4); cti = (b == 3) ? 3'b111 : 3'b010;
      step();
      chk($sformatf("burst_ack%0d", b), ack, 1);
      chk($sformatf("burst_dat%0d", b), dat_o, bexp[b]);
      $display("burst beat %0d ack=%0b dat=0x%08h", b, ack, dat_o);
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    step();
    chk("burst_ack_drop", ack, 0);

    // cti=010 with bte!=00 behaves as classic
    cyc = 1'b1; stb = 1'b1; adr = 32'h0C; cti = 3'b010; bte = 2'b01;
    step();
    chk("bte_ack", ack, 1);
    chk("bte_dat", dat_o, {24'd0, ien_m});
    step();
    chk("bte_classic_gap", ack, 0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
    step();

    // Strobe dropped mid-burst: dropped beat has no effect
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0C; dat_i = 32'h11; cti = 3'b010;
    step();
    chk("drop_first_ack", ack, 1);
    stb = 1'b0; dat_i = 32'h22;
    step();
    chk("drop_ack_low", ack, 0);
    cyc = 1'b0; we = 1'b0; cti = 3'b000;
    step();
    ien_m = 8'h11;
    xfer(1'b0, 4'd3, 32'h0, 4'hF);
    chk("drop_ien", r_dat, {24'd0, ien_m});

    // Randomized patterns and accesses against the model
    for (int p = 0; p < 8; p++) begin
      newp = 8'($urandom_range(0, 255));
      edge_m = edge_m | (newp & ~btn_m);
      btn_m = newp; btn = newp;
      repeat (26) step();
      for (int q = 0; q < 6; q++) begin
        w  = 1'($urandom_range(0, 1));
        o  = 4'($urandom_range(0, 7));
        s  = 4'($urandom_range(0, 15));
        wd = $urandom;
        if (w && o == 4'd4) wd = 32'($urandom_range(0, 3));
        bad = (o > 4'd4) || (w && o < 4'd2);
        d = model_rd(o);
        xfer(w, o, wd, s);
        if (w && !bad) model_wr(o, wd, s);
        chk($sformatf("rnd%0d_%0d_ack", p, q), r_ack, !bad);
        chk($sformatf("rnd%0d_%0d_err", p, q), r_err, bad);
        if (!w) chk($sformatf("rnd%0d_%0d_dat", p, q), r_dat, bad ? 32'd0 : d);
        chk($sformatf("rnd%0d_%0d_irq", p, q), r_irq1, |(edge_m & ien_m));
      end
    end

    // Reset asserted in the middle of a burst
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; cti = 3'b010; sel = 4'hF;
    step();
    chk("rstb_first_ack", ack, 1);
    adr = 32'h4;
    #2 rst_n = 1'b0;
    #1;
    chk("rstb_ack_now", ack, 0);
    chk("rstb_dat_now", dat_o, 0);
    chk("rstb_irq_now", irq, 0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    ien_m = '0; edge_m = '0; deb_m = 16'hC350;
    xfer(1'b0, 4'd3, 32'h0, 4'hF);
    chk("post_rst_ien", r_dat, model_rd(4'd3));
    xfer(1'b0, 4'd2, 32'h0, 4'hF);
    chk("post_rst_edge", r_dat, model_rd(4'd2));
    xfer(1'b0, 4'd4, 32'h0, 4'hF);
    chk("post_rst_deb", r_dat, model_rd(4'd4));
    xfer(1'b0, 4'd0, 32'h0, 4'hF);
    chk("post_rst_data", r_dat, 32'h0);
    chk("post_rst_irq", r_irq1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
